// File: rtl/output_port_allocator.sv
// output_port_allocator: round-robin wormhole output allocator with downstream credit tracking.
// Define OUTPUT_ALLOC_STATS_EN to add the stat_flits / stat_stall counters.
module output_port_allocator #(
    parameter int NUM_INPUTS   = 5,
    parameter int CREDIT_DEPTH = 2,
    parameter int CNT_W        = $clog2(CREDIT_DEPTH + 1),
    parameter int IDX_W        = $clog2(NUM_INPUTS)
) (
    input  logic                  clk_noc,
    input  logic                  rst_noc_sync,
    input  logic [NUM_INPUTS-1:0] req,
    input  logic [NUM_INPUTS-1:0] req_tail,
    input  logic [NUM_INPUTS-1:0] turn_disable,
    input  logic                  credit_in,
    output logic [NUM_INPUTS-1:0] grant,
    output logic                  xfer,
    output logic                  locked,
    output logic [IDX_W-1:0]      locked_idx,
    output logic [CNT_W-1:0]      credit_count,
    output logic                  credit_err
`ifdef OUTPUT_ALLOC_STATS_EN
    ,
    output logic [31:0]           stat_flits,
    output logic [31:0]           stat_stall
`endif
);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t                r_state, w_state_nxt;
    logic [IDX_W-1:0]      r_idx, w_idx_nxt, r_ptr, w_ptr_nxt;
    logic [IDX_W-1:0]      w_winner, w_owner, w_j;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic                  r_err;
    logic [NUM_INPUTS-1:0] w_elig;
    logic                  w_any, w_has_credit, w_req_ok, w_tail, w_overflow;

    assign w_elig       = req & ~turn_disable;
    assign w_has_credit = r_cnt != '0;

    // Scan downwards so the last hit is the first eligible input at or after the pointer.
    always_comb begin
        w_winner = '0;
        w_j      = '0;
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
            w_j = IDX_W'((int'(r_ptr) + k) % NUM_INPUTS);
            if (w_elig[w_j]) w_winner = w_j;
        end
    end

    assign w_owner  = (r_state == LOCKED) ? r_idx : w_winner;
    assign w_any    = (r_state == LOCKED) | (|w_elig);
    assign w_req_ok = (r_state == LOCKED) ? req[r_idx] : w_any;
    assign w_tail   = req_tail[w_owner];

    assign grant        = (rst_noc_sync | ~w_any) ? '0 : (NUM_INPUTS'(1) << w_owner);
    assign xfer         = ~rst_noc_sync & w_req_ok & w_has_credit;
    assign locked       = r_state == LOCKED;
    assign locked_idx   = r_idx;
    assign credit_count = r_cnt;
    assign credit_err   = r_err;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_ptr_nxt   = r_ptr;
        if (xfer && !w_tail) begin
            w_state_nxt = LOCKED;
            w_idx_nxt   = w_owner;
        end
        if (xfer && w_tail) begin
            w_state_nxt = IDLE;
            w_ptr_nxt   = (w_owner == IDX_W'(NUM_INPUTS - 1)) ? '0 : w_owner + 1'b1;
        end
    end

    // A credit returned into a full counter is a protocol violation: hold the count, flag it.
    assign w_overflow = credit_in & ~xfer & (r_cnt == CNT_W'(CREDIT_DEPTH));
    assign w_cnt_nxt  = w_overflow ? r_cnt : r_cnt - CNT_W'(xfer) + CNT_W'(credit_in);

    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_ptr   <= '0;
            r_cnt   <= CNT_W'(CREDIT_DEPTH);
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= r_err | w_overflow;
        end
    end

`ifdef OUTPUT_ALLOC_STATS_EN
    logic [31:0] r_flits, r_stall;
    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            r_flits <= '0;
            r_stall <= '0;
        end else begin
            r_flits <= r_flits + 32'(xfer);
            r_stall <= r_stall + 32'(w_any & ~w_has_credit);
        end
    end
    assign stat_flits = r_flits;
    assign stat_stall = r_stall;
`endif
endmodule

// File: tb/tb_output_port_allocator.sv
// tb_output_port_allocator: directed plus random traffic against a packet-level reference model.
module tb_output_port_allocator;
    localparam int N     = 5;
    localparam int DEPTH = 2;

    logic         clk_noc = 1'b0;
    logic         rst_noc_sync = 1'b1;
    logic         credit_in = 1'b0;
    logic [N-1:0] req = '0, req_tail = '0, turn_disable = '0;
    logic [N-1:0] grant;
    logic         xfer, locked, credit_err;
    logic [2:0]   locked_idx;
    logic [1:0]   credit_count;
`ifdef OUTPUT_ALLOC_STATS_EN
    logic [31:0]  stat_flits, stat_stall;
`endif

    int compared = 0;
    int mismatched = 0;

    bit           m_locked, m_err;
    int           m_owner, m_ptr, m_cred;
    logic [N-1:0] e_grant;
    bit           e_xfer;
    int           e_win;

    output_port_allocator dut (
        .clk_noc(clk_noc), .rst_noc_sync(rst_noc_sync), .req(req), .req_tail(req_tail),
        .turn_disable(turn_disable), .credit_in(credit_in), .grant(grant), .xfer(xfer),
        .locked(locked), .locked_idx(locked_idx), .credit_count(credit_count),
        .credit_err(credit_err)
`ifdef OUTPUT_ALLOC_STATS_EN
        , .stat_flits(stat_flits), .stat_stall(stat_stall)
`endif
    );

    always #5 clk_noc = ~clk_noc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_owner = 0; m_ptr = 0; m_cred = DEPTH; m_err = 0;
    endtask

    // Who owns the output this cycle and whether a flit can leave.
    task automatic model_eval();
        e_grant = '0;
        e_win   = -1;
        if (m_locked) begin
            e_win   = m_owner;
            e_grant[m_owner] = 1'b1;
            e_xfer  = req[m_owner] && m_cred > 0;
        end else begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (e_win < 0 && req[j] && !turn_disable[j]) e_win = j;
            end
            if (e_win >= 0) e_grant[e_win] = 1'b1;
            e_xfer = e_win >= 0 && m_cred > 0;
        end
    endtask

    task automatic model_update();
        if (e_xfer) begin
            if (req_tail[e_win]) begin
                m_locked = 0;
                m_ptr = (e_win + 1) % N;
            end else begin
                m_locked = 1;
                m_owner = e_win;
            end
        end
        if (e_xfer && !credit_in) m_cred--;
        else if (!e_xfer && credit_in) begin
            if (m_cred == DEPTH) m_err = 1;
            else m_cred++;
        end
    endtask

    task automatic step(input logic [N-1:0] rq, input logic [N-1:0] tl, input logic [N-1:0] td,
                        input logic ci);
        chk("locked", locked, m_locked);
        chk("credit_count", credit_count, m_cred);
        chk("credit_err", credit_err, m_err);
        if (m_locked) chk("locked_idx", locked_idx, m_owner);
        req = rq; req_tail = tl; turn_disable = td; credit_in = ci;
        #2;
        model_eval();
        chk("grant", grant, e_grant);
        chk("xfer", xfer, e_xfer);
        @(posedge clk_noc); #1;
        model_update();
    endtask

    task automatic do_reset();
        rst_noc_sync = 1'b1;
        req = N'($urandom); req_tail = N'($urandom); credit_in = 1'b0;
        #2;
        chk("rst_grant", grant, 0);
        chk("rst_xfer", xfer, 0);
        @(posedge clk_noc); #1;
        rst_noc_sync = 1'b0;
        req = '0; req_tail = '0; turn_disable = '0;
        model_reset();
    endtask

    initial begin
        model_reset();
        @(posedge clk_noc); #1;
        do_reset();
        chk("reset_credits", credit_count, 2);
        chk("reset_locked", locked, 0);
        chk("reset_err", credit_err, 0);
        chk("reset_idx", locked_idx, 0);
        step(5'b00000, 5'b00000, 5'b00000, 1'b0);

        step(5'b00110, 5'b00000, 5'b00000, 1'b1);
        chk("tp_lock_idx1", locked_idx, 1);
        step(5'b00110, 5'b00000, 5'b00000, 1'b1);
        step(5'b00110, 5'b00000, 5'b00000, 1'b1);
        step(5'b00110, 5'b00010, 5'b00000, 1'b1);
        step(5'b00100, 5'b00100, 5'b00000, 1'b1);

        repeat (4) step(5'b01001, 5'b01001, 5'b00000, 1'b1);

        step(5'b00100, 5'b00000, 5'b00000, 1'b0);
        step(5'b00100, 5'b00000, 5'b00000, 1'b0);
        chk("tp_drained", credit_count, 0);
        step(5'b00100, 5'b00100, 5'b00000, 1'b0);
        step(5'b00100, 5'b00100, 5'b00000, 1'b1);
        step(5'b00100, 5'b00100, 5'b00000, 1'b0);
        chk("tp_tail_idle", locked, 0);
        chk("tp_tail_cnt", credit_count, 0);
        step(5'b00000, 5'b00000, 5'b00000, 1'b1);
        step(5'b00000, 5'b00000, 5'b00000, 1'b1);

        repeat (3) step(5'b00010, 5'b00010, 5'b00010, 1'b0);
        step(5'b00010, 5'b00010, 5'b00000, 1'b1);

        step(5'b00000, 5'b00000, 5'b00000, 1'b1);
        chk("tp_err_set", credit_err, 1);
        chk("tp_err_cnt", credit_count, 2);
        step(5'b00001, 5'b00000, 5'b00000, 1'b0);
        chk("tp_mid_locked", locked, 1);
        do_reset();
        chk("tp_rst_locked", locked, 0);
        chk("tp_rst_cnt", credit_count, 2);
        chk("tp_rst_err", credit_err, 0);

        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            else step(N'($urandom), N'($urandom),
                      ($urandom_range(0, 3) == 0) ? N'($urandom) : N'(0),
                      1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
